dp_issue_controller: RTL and testbench
======================================

Name: dp_issue_controller

Overview:
- Multi-cycle control FSM on the issue side of the instruction-fetch interface.
- Drives write_ir/write_pc into the fetch unit, consumes W_IR_valid and the latched IR, and decodes ARM-style data-processing instructions into register-file, ALU and shifter controls.
- Owns the architectural NZCV register and feeds it back to fetch for condition evaluation, closing the fetch/execute loop.

Parameters:
- NZCV_RST, 4'h0, reset value of the flags register.
- ILLEGAL_PULSE, 1, 1 = assert illegal for one cycle on an unsupported encoding; 0 = never assert illegal (silent NOP).

Ports:
- clk  input  1  system clock; state updates on posedge.
- rst  input  1  synchronous reset, active-low (asserted when rst=0, sampled on posedge clk).
- W_IR_valid  input  1  from fetch: condition passed and IR is being loaded this FETCH cycle.
- IR  input  32  latched instruction from fetch.
- alu_nzcv  input  4  ALU/shifter result flags {N,Z,C,V}, valid during WB.
- write_ir  output  1  IR load request to fetch.
- write_pc  output  1  PC+4 request to fetch.
- NZCV  output  4  architectural flags to fetch.
- rn_addr  output  4  first-operand register.
- rm_addr  output  4  second-operand register, used when imm_sel=0.
- rd_addr  output  4  destination register.
- alu_op  output  4  IR[24:21] opcode.
- imm_sel  output  1  1 = operand2 is imm32.
- imm32  output  32  rotated immediate.
- shift_type  output  2  IR[6:5].
- shift_imm  output  5  IR[11:7].
- write_reg  output  1  register-file write enable.
- illegal  output  1  unsupported-encoding pulse.

Behaviour:
- States:
  - FETCH: write_ir=1, write_pc=1. Next state is DECODE if W_IR_valid=1, else FETCH. A condition-failed instruction is skipped in 1 cycle with the PC still advanced.
  - DECODE:
    - Supported means IR[27:26]=00, and IR[4]=0 when IR[25]=0.
    - Supported: register all decode fields at the posedge, then go to EXEC.
    - Unsupported: illegal=1 for this cycle (if ILLEGAL_PULSE), then go to FETCH.
  - EXEC: decode outputs held stable; ALU settles; next state WB.
  - WB: apply write_reg and the flag update; next state FETCH.
- Outputs:
  - write_ir and write_pc are Moore outputs, high only in FETCH.
  - write_reg is high only in WB, and only when alu_op is not in 8..11 (TST/TEQ/CMP/CMN).
- Decode fields:
  - rn_addr = IR[19:16], rd_addr = IR[15:12], rm_addr = IR[3:0].
  - imm_sel = IR[25].
  - imm32 = {24'h0, IR[7:0]} rotated right by 2*IR[11:8] (mod 32).
  - shift_type and shift_imm are passed through unchanged even when imm_sel=1.
- Flag write condition: flag_wr = IR[20] | (alu_op in 8..11).
- Flag update at the WB posedge when flag_wr=1:
  - N, Z and C are taken from alu_nzcv.
  - V is taken from alu_nzcv only for arithmetic ops 2..7, 10 and 11; otherwise V is preserved.
- Cycle counts: 4 per executed instruction, 1 per skipped instruction, 2 per unsupported instruction.
- Reset:
  - rst=0 on a posedge puts the FSM in FETCH, sets NZCV=NZCV_RST and clears every other registered output to 0.
  - The first posedge with rst=1 executes FETCH.
  - Reset dominates all other inputs.
  - Reset mid-instruction aborts it: no write_reg, no flag update.
- Outside DECODE, IR changes are ignored because the decode fields are registered.

Optional Feature:
- Macro DP_ISSUE_STEP_EN.
- Defined:
  - Adds input port step (1 bit) and state HOLD.
  - WB goes to HOLD. HOLD goes to FETCH on a posedge with step=1, otherwise it stays in HOLD.
  - All enables are 0 in HOLD.
  - Reset goes to FETCH, not HOLD.
- Undefined: no step port; WB goes directly to FETCH.

Test Plan:
- Reset: hold rst=0 for 3 cycles with NZCV_RST=0 -> NZCV=0, write_reg=0, illegal=0. On the first cycle after release, write_ir=1 and write_pc=1.
- IR=0xE3A01005 (MOV r1,#5) with W_IR_valid=1:
  - DECODE->EXEC->WB: rd_addr=1, alu_op=4'hD, imm_sel=1, imm32=5.
  - write_reg=1 in WB only; NZCV unchanged; next FETCH 4 cycles after the previous one.
- IR=0xE3510005 (CMP r1,#5) with alu_nzcv=4'b0110 -> write_reg=0 throughout; NZCV=4'b0110 after WB.
- Rotation and V handling:
  - IR=0xE3B014FF (MOVS r1,#0xFF000000), prior NZCV=4'b0001, alu_nzcv=4'b1000 -> imm32=32'hFF000000; NZCV=4'b1001 (V preserved).
  - IR=0xE0912003 (ADDS r2,r1,r3), alu_nzcv=4'b0011 -> imm_sel=0, rm_addr=3, rn_addr=1, rd_addr=2; NZCV=4'b0011.
- W_IR_valid=0 in FETCH for 3 consecutive cycles -> FSM stays in FETCH; write_pc=1 each cycle; no write_reg.
- IR=0xEA000000 (branch) -> illegal=1 for exactly the DECODE cycle; FETCH on the next cycle; no write_reg.
- Reset mid-instruction: assert rst=0 during EXEC -> no write_reg and no NZCV change; FSM in FETCH after release.

Source files
------------

// File: rtl/dp_issue_controller.sv
// ---------------------------------------------------------------------------
// dp_issue_controller
//
// Issue-side control FSM for the instruction-fetch interface. It asks fetch
// for the next instruction, decodes ARM-style data-processing encodings into
// register-file / ALU / shifter controls, and owns the architectural NZCV
// flags that fetch uses for condition evaluation.
//
// Parameters:
//   NZCV_RST       reset value of the flags register
//   ILLEGAL_PULSE  1: pulse illegal for one cycle on an unsupported encoding
//                  0: unsupported encodings are dropped silently
//
// Build option:
//   DP_ISSUE_STEP_EN  when defined, adds the step input and a HOLD state
//                     between WB and the next FETCH (single-step support).
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous reset, active low
//   step        (DP_ISSUE_STEP_EN only) release from HOLD
//   W_IR_valid  fetch: condition passed, IR being loaded this FETCH cycle
//   IR          latched instruction from fetch
//   alu_nzcv    ALU/shifter result flags {N,Z,C,V}, valid during WB
//   write_ir    IR load request to fetch (FETCH only)
//   write_pc    PC+4 request to fetch (FETCH only)
//   NZCV        architectural flags to fetch
//   rn_addr     first-operand register
//   rm_addr     second-operand register (used when imm_sel=0)
//   rd_addr     destination register
//   alu_op      data-processing opcode
//   imm_sel     1: operand2 is imm32
//   imm32       rotated immediate
//   shift_type  shifter type
//   shift_imm   shifter amount
//   write_reg   register-file write enable (WB only)
//   illegal     unsupported-encoding pulse (DECODE only)
//
// state  | meaning
// -------+--------------------------------------------------------------
// FETCH  | request IR load and PC+4; leave when fetch reports a valid IR
// DECODE | check encoding, register decode fields, or flag illegal
// EXEC   | decode outputs stable, ALU settles
// WB     | register write and flag update
// HOLD   | (DP_ISSUE_STEP_EN) all enables off until step=1
// ---------------------------------------------------------------------------
module dp_issue_controller #(
    parameter logic [3:0] NZCV_RST      = 4'h0,
    parameter bit         ILLEGAL_PULSE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
`ifdef DP_ISSUE_STEP_EN
    input  logic        step,
`endif
    input  logic        W_IR_valid,
    input  logic [31:0] IR,
    input  logic [3:0]  alu_nzcv,
    output logic        write_ir,
    output logic        write_pc,
    output logic [3:0]  NZCV,
    output logic [3:0]  rn_addr,
    output logic [3:0]  rm_addr,
    output logic [3:0]  rd_addr,
    output logic [3:0]  alu_op,
    output logic        imm_sel,
    output logic [31:0] imm32,
    output logic [1:0]  shift_type,
    output logic [4:0]  shift_imm,
    output logic        write_reg,
    output logic        illegal
);

`ifdef DP_ISSUE_STEP_EN
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HOLD   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3
    } state_t;
`endif

    state_t state, state_nxt;

    logic        s_bit;        // IR[20] captured at decode
    logic        ir_supported;
    logic        dec_load;
    logic        op_is_test;   // TST/TEQ/CMP/CMN: flags only, no register write
    logic        op_is_arith;  // ops whose V flag comes from the ALU
    logic        flag_wr;
    logic [31:0] imm8_zx;
    logic [63:0] imm_dbl;
    logic [4:0]  imm_rot;
    logic [31:0] imm_rotated;
    logic        unused_cond;

    // Condition field is evaluated by fetch, not here.
    assign unused_cond = ^IR[31:28];

    // Data-processing only; register-operand forms with IR[4]=1 are
    // register-specified shifts / multiplies and are not handled.
    assign ir_supported = (IR[27:26] == 2'b00) && (IR[25] || !IR[4]);

    // Rotate right by 2*rot: doubling the word lets a plain part-select
    // pick out the rotated value.
    assign imm8_zx     = {24'h0, IR[7:0]};
    assign imm_dbl     = {imm8_zx, imm8_zx};
    assign imm_rot     = {IR[11:8], 1'b0};
    assign imm_rotated = imm_dbl[imm_rot +: 32];

    assign op_is_test = (alu_op[3:2] == 2'b10);

    always_comb begin
        op_is_arith = 1'b0;
        case (alu_op)
            4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10, 4'd11: op_is_arith = 1'b1;
            default:                                          op_is_arith = 1'b0;
        endcase
    end

    assign flag_wr = s_bit | op_is_test;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and Moore/decode-cycle outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        write_ir  = 1'b0;
        write_pc  = 1'b0;
        write_reg = 1'b0;
        illegal   = 1'b0;
        dec_load  = 1'b0;
        case (state)
            S_FETCH: begin
                write_ir = 1'b1;
                write_pc = 1'b1;
                if (W_IR_valid) begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (ir_supported) begin
                    dec_load  = 1'b1;
                    state_nxt = S_EXEC;
                end else begin
                    illegal   = ILLEGAL_PULSE;
                    state_nxt = S_FETCH;
                end
            end
            S_EXEC: begin
                state_nxt = S_WB;
            end
            S_WB: begin
                write_reg = !op_is_test;
`ifdef DP_ISSUE_STEP_EN
                state_nxt = S_HOLD;
`else
                state_nxt = S_FETCH;
`endif
            end
`ifdef DP_ISSUE_STEP_EN
            S_HOLD: begin
                if (step) begin
                    state_nxt = S_FETCH;
                end
            end
`endif
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Decode field registers: loaded only on a supported DECODE, so IR may
    // change freely in every other state.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            rn_addr    <= 4'h0;
            rm_addr    <= 4'h0;
            rd_addr    <= 4'h0;
            alu_op     <= 4'h0;
            imm_sel    <= 1'b0;
            imm32      <= 32'h0;
            shift_type <= 2'b00;
            shift_imm  <= 5'd0;
            s_bit      <= 1'b0;
        end else if (dec_load) begin
            rn_addr    <= IR[19:16];
            rm_addr    <= IR[3:0];
            rd_addr    <= IR[15:12];
            alu_op     <= IR[24:21];
            imm_sel    <= IR[25];
            imm32      <= imm_rotated;
            shift_type <= IR[6:5];
            shift_imm  <= IR[11:7];
            s_bit      <= IR[20];
        end
    end

    // -----------------------------------------------------------------------
    // Architectural flags. Logical ops keep the previous V.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            NZCV <= NZCV_RST;
        end else if ((state == S_WB) && flag_wr) begin
            NZCV[3:1] <= alu_nzcv[3:1];
            if (op_is_arith) begin
                NZCV[0] <= alu_nzcv[0];
            end
        end
    end

endmodule

// File: tb/tb_dp_issue_controller.sv
module tb_dp_issue_controller;

    logic        clk;
    logic        rst;
    logic        step;
    logic        W_IR_valid;
    logic [31:0] IR;
    logic [3:0]  alu_nzcv;
    logic        write_ir;
    logic        write_pc;
    logic [3:0]  NZCV;
    logic [3:0]  rn_addr;
    logic [3:0]  rm_addr;
    logic [3:0]  rd_addr;
    logic [3:0]  alu_op;
    logic        imm_sel;
    logic [31:0] imm32;
    logic [1:0]  shift_type;
    logic [4:0]  shift_imm;
    logic        write_reg;
    logic        illegal;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]  rn;
        logic [3:0]  rm;
        logic [3:0]  rd;
        logic [3:0]  op;
        logic        isel;
        logic [31:0] imm;
        logic [1:0]  st;
        logic [4:0]  sh;
        logic        wr;
        logic [3:0]  nzcv;
    } exp_t;

    exp_t exp_q[$];
    logic [3:0] model_nzcv;

    dp_issue_controller #(
        .NZCV_RST      (4'h0),
        .ILLEGAL_PULSE (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef DP_ISSUE_STEP_EN
        .step       (step),
`endif
        .W_IR_valid (W_IR_valid),
        .IR         (IR),
        .alu_nzcv   (alu_nzcv),
        .write_ir   (write_ir),
        .write_pc   (write_pc),
        .NZCV       (NZCV),
        .rn_addr    (rn_addr),
        .rm_addr    (rm_addr),
        .rd_addr    (rd_addr),
        .alu_op     (alu_op),
        .imm_sel    (imm_sel),
        .imm32      (imm32),
        .shift_type (shift_type),
        .shift_imm  (shift_imm),
        .write_reg  (write_reg),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference decode: rotation done one bit at a time.
    function automatic exp_t model(input logic [31:0] ir, input logic [3:0] alu,
                                   input logic [3:0] prior);
        exp_t e;
        logic [31:0] v;
        logic [3:0]  op;
        logic        fw;
        v = {24'h0, ir[7:0]};
        for (int i = 0; i < 2 * int'(ir[11:8]); i++) v = {v[0], v[31:1]};
        op     = ir[24:21];
        e.rn   = ir[19:16];
        e.rm   = ir[3:0];
        e.rd   = ir[15:12];
        e.op   = op;
        e.isel = ir[25];
        e.imm  = v;
        e.st   = ir[6:5];
        e.sh   = ir[11:7];
        e.wr   = !(op inside {4'd8, 4'd9, 4'd10, 4'd11});
        fw     = ir[20] || (op inside {4'd8, 4'd9, 4'd10, 4'd11});
        e.nzcv = prior;
        if (fw) begin
            e.nzcv[3:1] = alu[3:1];
            if (op inside {4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10, 4'd11})
                e.nzcv[0] = alu[0];
        end
        return e;
    endfunction

    // One supported instruction from FETCH back to the next FETCH.
    // abort=1 pulls reset during EXEC.
    task automatic run_instr(input string name, input logic [31:0] ir,
                             input logic [3:0] alu, input bit abort);
        exp_t e;
        exp_q.push_back(model(ir, alu, model_nzcv));
        chk({name, "_fetch_wir"}, 32'(write_ir), 32'd1);
        IR = ir;
        W_IR_valid = 1'b1;
        tick();
        // DECODE
        W_IR_valid = 1'b0;
        chk({name, "_dec_illegal"}, 32'(illegal), 32'd0);
        chk({name, "_dec_wreg"}, 32'(write_reg), 32'd0);
        tick();
        // EXEC
        e = exp_q.pop_front();
        chk({name, "_rn"}, 32'(rn_addr), 32'(e.rn));
        chk({name, "_rm"}, 32'(rm_addr), 32'(e.rm));
        chk({name, "_rd"}, 32'(rd_addr), 32'(e.rd));
        chk({name, "_op"}, 32'(alu_op), 32'(e.op));
        chk({name, "_isel"}, 32'(imm_sel), 32'(e.isel));
        chk({name, "_imm32"}, imm32, e.imm);
        chk({name, "_stype"}, 32'(shift_type), 32'(e.st));
        chk({name, "_simm"}, 32'(shift_imm), 32'(e.sh));
        chk({name, "_exec_wreg"}, 32'(write_reg), 32'd0);
        chk({name, "_exec_wir"}, 32'(write_ir), 32'd0);
        IR = 32'hFFFF_FFFF;
        alu_nzcv = alu;
        if (abort) begin
            rst = 1'b0;
            tick();
            chk({name, "_abort_wreg"}, 32'(write_reg), 32'd0);
            chk({name, "_abort_nzcv"}, 32'(NZCV), 32'(model_nzcv));
            chk({name, "_abort_rd"}, 32'(rd_addr), 32'd0);
            tick();
            chk({name, "_abort_wreg2"}, 32'(write_reg), 32'd0);
            rst = 1'b1;
            alu_nzcv = 4'h0;
            chk({name, "_abort_fetch"}, 32'(write_ir), 32'd1);
            tick();
            chk({name, "_abort_nzcv2"}, 32'(NZCV), 32'(model_nzcv));
            chk({name, "_abort_fetch2"}, 32'(write_pc), 32'd1);
            return;
        end
        tick();
        // WB
        chk({name, "_wb_wreg"}, 32'(write_reg), 32'(e.wr));
        chk({name, "_wb_rd"}, 32'(rd_addr), 32'(e.rd));
        chk({name, "_wb_imm32"}, imm32, e.imm);
        chk({name, "_wb_wir"}, 32'(write_ir), 32'd0);
        tick();
        // back in FETCH, four cycles after the previous FETCH
        alu_nzcv = 4'h0;
        model_nzcv = e.nzcv;
        chk({name, "_nzcv"}, 32'(NZCV), 32'(e.nzcv));
        chk({name, "_next_fetch"}, 32'(write_ir), 32'd1);
        chk({name, "_next_wreg"}, 32'(write_reg), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        step = 1'b1;
        W_IR_valid = 1'b0;
        IR = 32'h0;
        alu_nzcv = 4'h0;
        model_nzcv = 4'h0;
        @(negedge clk);
        tick();
        tick();
        tick();
        chk("rst_nzcv", 32'(NZCV), 32'h0);
        chk("rst_wreg", 32'(write_reg), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_rd", 32'(rd_addr), 32'd0);
        chk("rst_imm32", imm32, 32'd0);
        rst = 1'b1;
        chk("rel_wir", 32'(write_ir), 32'd1);
        chk("rel_wpc", 32'(write_pc), 32'd1);
        tick();

        run_instr("mov", 32'hE3A0_1005, 4'b1111, 1'b0);
        chk("mov_imm5", imm32, 32'd5);
        chk("mov_nzcv_const", 32'(NZCV), 32'h0);
        run_instr("cmp", 32'hE351_0005, 4'b0110, 1'b0);
        chk("cmp_nzcv_const", 32'(NZCV), 32'b0110);
        run_instr("cmp_v", 32'hE351_0005, 4'b0001, 1'b0);
        run_instr("movs", 32'hE3B0_14FF, 4'b1000, 1'b0);
        chk("movs_imm_const", imm32, 32'hFF00_0000);
        chk("movs_nzcv_const", 32'(NZCV), 32'b1001);
        run_instr("adds", 32'hE091_2003, 4'b0011, 1'b0);
        chk("adds_nzcv_const", 32'(NZCV), 32'b0011);

        // Condition-failed fetches: stay in FETCH, PC keeps advancing.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("skip_wpc", 32'(write_pc), 32'd1);
            chk("skip_wir", 32'(write_ir), 32'd1);
            chk("skip_wreg", 32'(write_reg), 32'd0);
        end

        // Branch encoding is unsupported: one-cycle illegal, fields untouched.
        IR = 32'hEA00_0000;
        W_IR_valid = 1'b1;
        tick();
        W_IR_valid = 1'b0;
        chk("br_illegal", 32'(illegal), 32'd1);
        chk("br_wreg", 32'(write_reg), 32'd0);
        chk("br_wir", 32'(write_ir), 32'd0);
        tick();
        chk("br_illegal_off", 32'(illegal), 32'd0);
        chk("br_fetch", 32'(write_ir), 32'd1);
        chk("br_rd_kept", 32'(rd_addr), 32'd2);
        chk("br_nzcv", 32'(NZCV), 32'(model_nzcv));

        // Register-operand form with IR[4]=1 is also unsupported.
        IR = 32'hE081_2113;
        W_IR_valid = 1'b1;
        tick();
        W_IR_valid = 1'b0;
        chk("regshift_illegal", 32'(illegal), 32'd1);
        tick();
        chk("regshift_fetch", 32'(write_ir), 32'd1);

        // Clear flags so the reset value and the prior value coincide,
        // then abort an ADDS mid-instruction.
        run_instr("cmp_clr", 32'hE351_0005, 4'b0000, 1'b0);
        run_instr("abort", 32'hE091_2003, 4'b1111, 1'b1);
        run_instr("post", 32'hE1A0_3182, 4'b1010, 1'b0);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
